// File: rtl/logic_op_pkg.sv
// Shared encodings and default widths for the logical-op issuer and its logical unit.
package logic_op_pkg;

    localparam int unsigned DEF_W     = 32;
    localparam int unsigned DEF_TAG_W = 4;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        XOR_OP = 2'b00,
        NOT_OP = 2'b01,
        OR_OP  = 2'b10,
        AND_OP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op_issuer_if.sv
// Request/response valid-ready channels between a command source (master) and the issuer (slave).
interface logic_op_issuer_if
    import logic_op_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) ();

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_g;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_g, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_g, rsp_tag
    );

endinterface

// File: rtl/logical_unit.sv
// Combinational bitwise unit: G = A op B selected by L_sel (B unused for NOT).
module logical_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic [1:0]   L_sel,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] G
);

    always_comb begin
        G = '0;
        case (L_sel)
            XOR_OP:  G = A ^ B;
            NOT_OP:  G = ~A;
            OR_OP:   G = A | B;
            AND_OP:  G = A & B;
            default: G = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_issuer.sv
// Sequential front end for logical_unit: accept, execute, hold response until handshake.
// Optional result flags (rsp_zero/rsp_parity/rsp_ones) built when LOGIC_ISSUER_FLAGS_EN is defined.
module logic_op_issuer
    import logic_op_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned TAG_W = DEF_TAG_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_op_issuer_if.slave   bus,
    output logic [CNT_W-1:0]   op_count
`ifdef LOGIC_ISSUER_FLAGS_EN
    ,
    output logic               rsp_zero,
    output logic               rsp_parity,
    output logic [$clog2(W):0] rsp_ones
`endif
);

    localparam int unsigned ONES_W = $clog2(W) + 1;

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [W-1:0]     a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_g_q, rsp_g_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     g_c;
    logic             accept_c;
    logic             capture_c;

    // Accept only when the registered ready was visible to the requester.
    assign accept_c = (state_q == IDLE) && req_ready_q && bus.req_valid;

    logical_unit #(.W(W)) u_lu (
        .L_sel (op_q),
        .A     (a_q),
        .B     (b_q),
        .G     (g_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture_c   = 1'b0;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = rsp_valid_q;
        rsp_g_d     = rsp_g_q;
        rsp_tag_d   = rsp_tag_q;
        count_d     = count_q;
        case (state_q)
            IDLE: capture_c = accept_c;
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_g_d     = g_c;
                rsp_tag_d   = tag_q;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                count_d     = count_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_g_q     <= '0;
            rsp_tag_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_g_q     <= rsp_g_d;
            rsp_tag_q   <= rsp_tag_d;
            count_q     <= count_d;
            if (capture_c) begin
                op_q  <= bus.req_op;
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                tag_q <= bus.req_tag;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_g     = rsp_g_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign op_count      = count_q;

`ifdef LOGIC_ISSUER_FLAGS_EN
    logic              zero_q, parity_q;
    logic [ONES_W-1:0] ones_q, ones_c;

    always_comb begin
        ones_c = '0;
        for (int i = 0; i < int'(W); i++) ones_c = ones_c + ONES_W'(g_c[i]);
    end

    // Flags are sampled together with rsp_g and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            ones_q   <= '0;
        end else if (state_q == EXEC) begin
            zero_q   <= (g_c == '0);
            parity_q <= ^g_c;
            ones_q   <= ones_c;
        end
    end

    assign rsp_zero   = zero_q;
    assign rsp_parity = parity_q;
    assign rsp_ones   = ones_q;
`endif

endmodule

// File: tb/tb_logic_op_issuer.sv
// Directed, table-driven bench for logic_op_issuer plus a CNT_W=2 instance for counter wrap.
module tb_logic_op_issuer;
    import logic_op_pkg::*;

    localparam int unsigned W      = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W2 = 2;

    typedef struct {
        logic [1:0]       op;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     g;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_op_issuer_if #(.W(W), .TAG_W(TAG_W)) bus ();
    logic_op_issuer_if #(.W(W), .TAG_W(TAG_W)) busw ();
    logic [CNT_W-1:0]  op_count;
    logic [CNT_W2-1:0] op_count_w;

`ifdef LOGIC_ISSUER_FLAGS_EN
    logic               zero, parity, zero_w, parity_w;
    logic [$clog2(W):0] ones, ones_w;
`endif

    logic_op_issuer #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .op_count (op_count)
`ifdef LOGIC_ISSUER_FLAGS_EN
        ,
        .rsp_zero   (zero),
        .rsp_parity (parity),
        .rsp_ones   (ones)
`endif
    );

    logic_op_issuer #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W2)) u_dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busw.slave),
        .op_count (op_count_w)
`ifdef LOGIC_ISSUER_FLAGS_EN
        ,
        .rsp_zero   (zero_w),
        .rsp_parity (parity_w),
        .rsp_ones   (ones_w)
`endif
    );

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int hs_base;
    logic [CNT_W-1:0] exp_count;
    vec_t vecs[7];
    vec_t b2b[4];
    logic [CNT_W2-1:0] wrap_exp[5];

    always @(posedge clk) if (rst_n && bus.rsp_valid && bus.rsp_ready) hs_count <= hs_count + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_tag   = v.tag;
    endtask

    // One full transaction with rsp_ready high; request inputs scrambled after accept.
    task automatic do_op(input vec_t v);
        bus.rsp_ready = 1'b1;
        wait_ready();
        drive_req(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = ~v.op;
        bus.req_a     = ~v.a;
        bus.req_b     = ~v.b;
        bus.req_tag   = ~v.tag;
        chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("exec_req_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("rsp_g", 64'(bus.rsp_g), 64'(v.g));
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(v.tag));
`ifdef LOGIC_ISSUER_FLAGS_EN
        chk("rsp_zero", 64'(zero), 64'(v.g == '0));
        chk("rsp_parity", 64'(parity), 64'(^v.g));
        chk("rsp_ones", 64'(ones), 64'($countones(v.g)));
`endif
        @(negedge clk);
        exp_count = exp_count + CNT_W'(1);
        chk("post_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("op_count", 64'(op_count), 64'(exp_count));
        chk("post_req_ready", 64'(bus.req_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = '{2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3,  32'hF000_F000};
        vecs[1] = '{2'b01, 32'h0000_FFFF, 32'h1234_5678, 4'd5,  32'hFFFF_0000};
        vecs[2] = '{2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd7,  32'h0000_0000};
        vecs[3] = '{2'b10, 32'h0F0F_0000, 32'h0000_F0F0, 4'd9,  32'h0F0F_F0F0};
        vecs[4] = '{2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd15, 32'hF0F0_0F0F};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 4'd0,  32'h0000_0000};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 4'd12, 32'h8000_0001};
        b2b[0]  = '{2'b10, 32'h0000_0001, 32'h0000_0002, 4'd1, 32'h0000_0003};
        b2b[1]  = '{2'b00, 32'h0000_000F, 32'h0000_0005, 4'd2, 32'h0000_000A};
        b2b[2]  = '{2'b11, 32'h0000_000C, 32'h0000_000A, 4'd3, 32'h0000_0008};
        b2b[3]  = '{2'b01, 32'h0000_0000, 32'h5555_5555, 4'd4, 32'hFFFF_FFFF};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;
        busw.req_valid = 1'b0; busw.req_op = '0; busw.req_a = '0; busw.req_b = '0;
        busw.req_tag = '0; busw.rsp_ready = 1'b0;
        exp_count = '0;

        // Reset values
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_g", 64'(bus.rsp_g), 64'(0));
        chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'(0));
        chk("rst_op_count", 64'(op_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_req_ready_low", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        chk("rel_req_ready_high", 64'(bus.req_ready), 64'(1));

        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // Backpressure: response held for 10 cycles while request inputs churn
        bus.rsp_ready = 1'b0;
        wait_ready();
        v = '{2'b10, 32'hAAAA_0000, 32'h0000_5555, 4'd6, 32'hAAAA_5555};
        drive_req(v);
        @(negedge clk);
        bus.req_a = 32'h1234_5678;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("bp_rsp_g", 64'(bus.rsp_g), 64'(v.g));
            chk("bp_rsp_tag", 64'(bus.rsp_tag), 64'(v.tag));
            chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
            bus.req_op  = 2'(i);
            bus.req_a   = 32'(i * 32'h0101_0101);
            bus.req_tag = 4'(i);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        hs_base = hs_count;
        @(negedge clk);
        exp_count = exp_count + CNT_W'(1);
        chk("bp_done_valid", 64'(bus.rsp_valid), 64'(0));
        chk("bp_op_count", 64'(op_count), 64'(exp_count));
        chk("bp_req_ready", 64'(bus.req_ready), 64'(1));
        @(negedge clk);
        chk("bp_one_handshake", 64'(hs_count - hs_base), 64'(1));

        // Asynchronous reset while in RESP
        bus.rsp_ready = 1'b0;
        wait_ready();
        drive_req('{2'b00, 32'h1, 32'h3, 4'd2, 32'h2});
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_op_count", 64'(op_count), 64'(0));
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_rsp_g", 64'(bus.rsp_g), 64'(0));
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));

        // Back-to-back with req_valid held high
        bus.rsp_ready = 1'b1;
        hs_base = hs_count;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            drive_req(b2b[i]);
            @(negedge clk);
            @(negedge clk);
            chk("b2b_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("b2b_rsp_g", 64'(bus.rsp_g), 64'(b2b[i].g));
            chk("b2b_rsp_tag", 64'(bus.rsp_tag), 64'(b2b[i].tag));
            exp_count = exp_count + CNT_W'(1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_op_count", 64'(op_count), 64'(exp_count));
        chk("b2b_responses", 64'(hs_count - hs_base), 64'(4));

        // Counter wrap on the CNT_W=2 instance
        busw.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            while (busw.req_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("wrap_req_ready", 64'(busw.req_ready), 64'(1));
            busw.req_valid = 1'b1;
            busw.req_op    = 2'b10;
            busw.req_a     = 32'(k + 1);
            busw.req_b     = 32'h0;
            busw.req_tag   = 4'(k);
            @(negedge clk);
            busw.req_valid = 1'b0;
            @(negedge clk);
            chk("wrap_rsp_g", 64'(busw.rsp_g), 64'(k + 1));
            @(negedge clk);
            chk("wrap_op_count", 64'(op_count_w), 64'(wrap_exp[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
